// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction loader for ProcessorStructural.
// Receives a byte stream over valid/ready framed as a length byte N (words),
// 4*N little-endian data bytes and an XOR checksum byte. Each assembled
// word is written to instruction memory. The core is held in reset until
// the whole image has arrived and its checksum matches.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   RxValid/RxData      upstream byte stream
//   RxReady             byte accepted on an edge with RxValid && RxReady
//   Reload              single-cycle restart request (wins over a byte)
//   ImemWE/Addr/WData   one-cycle instruction-memory word write
//   CoreRST             processor reset, low only after a good image
//   Busy/Done/Error     status: receiving / running / failed
module imem_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RxValid,
  input  logic [7:0]        RxData,
  output logic              RxReady,
  input  logic              Reload,
  output logic              ImemWE,
  output logic [ADDR_W-1:0] ImemAddr,
  output logic [31:0]       ImemWData,
  output logic              CoreRST,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_LEN,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERR
  } state_t;

  state_t            state, state_d;
  logic [1:0]        lane, lane_d;
  logic [ADDR_W-1:0] index, index_d;
  logic [ADDR_W-1:0] last, last_d;     // word index of the final word (N-1)
  logic [7:0]        csum, csum_d;
  logic [23:0]       word, word_d;     // lanes 0..2; lane 3 comes straight from RxData
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic              accept;
  logic              rx_phase_d;

  // RxReady is the registered output itself, so acceptance matches what
  // upstream observes in the same cycle.
  assign accept = RxValid && RxReady && !Reload;

  always_comb begin
    state_d = state;
    lane_d  = lane;
    index_d = index;
    last_d  = last;
    csum_d  = csum;
    word_d  = word;
    we_d    = 1'b0;
    addr_d  = ImemAddr;
    wdata_d = ImemWData;

    if (Reload) begin
      state_d = S_LEN;
      lane_d  = '0;
      index_d = '0;
      csum_d  = '0;
    end else if (accept) begin
      case (state)
        S_LEN: begin
          lane_d  = '0;
          index_d = '0;
          csum_d  = '0;
          if (RxData == 8'd0) begin
            state_d = S_CHECK;
          end else if (32'(RxData) > DEPTH) begin
            state_d = S_ERR;
          end else begin
            state_d = S_LOAD;
            last_d  = ADDR_W'(RxData - 8'd1);
          end
        end
        S_LOAD: begin
          csum_d = csum ^ RxData;
          lane_d = lane + 2'd1;
          case (lane)
            2'd0: word_d[7:0]   = RxData;
            2'd1: word_d[15:8]  = RxData;
            2'd2: word_d[23:16] = RxData;
            default: begin
              we_d    = 1'b1;
              addr_d  = index;
              wdata_d = {RxData, word};
              index_d = index + ADDR_W'(1);
              if (index == last) begin
                state_d = S_CHECK;
              end
            end
          endcase
        end
        S_CHECK: begin
          state_d = (RxData == csum) ? S_RUN : S_ERR;
        end
        default: ;
      endcase
    end

    rx_phase_d = (state_d == S_LEN) || (state_d == S_LOAD) || (state_d == S_CHECK);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_LEN;
      lane      <= '0;
      index     <= '0;
      last      <= '0;
      csum      <= '0;
      word      <= '0;
      RxReady   <= 1'b0;
      ImemWE    <= 1'b0;
      ImemAddr  <= '0;
      ImemWData <= '0;
      CoreRST   <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      state     <= state_d;
      lane      <= lane_d;
      index     <= index_d;
      last      <= last_d;
      csum      <= csum_d;
      word      <= word_d;
      // Status outputs are registered from the next state so they change
      // on the same edge as the state they describe.
      RxReady   <= rx_phase_d;
      Busy      <= rx_phase_d;
      ImemWE    <= we_d;
      ImemAddr  <= addr_d;
      ImemWData <= wdata_d;
      CoreRST   <= (state_d != S_RUN);
      Done      <= (state_d == S_RUN);
      Error     <= (state_d == S_ERR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a frame-position model predicts every
// output each cycle; directed frames plus literal checks pin the model.
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              RxValid = 1'b0;
  logic [7:0]        RxData = 8'h00;
  logic              RxReady;
  logic              Reload = 1'b0;
  logic              ImemWE;
  logic [ADDR_W-1:0] ImemAddr;
  logic [31:0]       ImemWData;
  logic              CoreRST, Busy, Done, Error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .RxValid(RxValid), .RxData(RxData), .RxReady(RxReady),
    .Reload(Reload), .ImemWE(ImemWE), .ImemAddr(ImemAddr), .ImemWData(ImemWData),
    .CoreRST(CoreRST), .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: frame position based ----------------
  localparam int M_RECV = 0, M_RUN = 1, M_ERR = 2;
  int         m_mode, m_pos, m_n;
  logic [7:0] m_x;
  logic [7:0] m_buf [4];
  logic       e_ready, e_we, e_core, e_busy, e_done, e_err;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0]       e_wdata;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_mode = M_RECV; m_pos = 0; m_n = 0; m_x = 8'h00;
      e_ready = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
      e_core = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    end else begin
      e_we = 1'b0;
      if (Reload) begin
        m_mode = M_RECV; m_pos = 0; m_x = 8'h00;
      end else if (RxValid && e_ready) begin
        if (m_pos == 0) begin
          m_n = int'(RxData);
          m_x = 8'h00;
          if (m_n > DEPTH) m_mode = M_ERR;
          else m_pos = 1;
        end else if (m_pos <= 4 * m_n) begin
          m_x = m_x ^ RxData;
          m_buf[(m_pos - 1) % 4] = RxData;
          if (m_pos % 4 == 0) begin
            e_we    = 1'b1;
            e_addr  = ADDR_W'(m_pos / 4 - 1);
            e_wdata = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
          end
          m_pos++;
        end else begin
          m_mode = (RxData == m_x) ? M_RUN : M_ERR;
        end
      end
      e_ready = (m_mode == M_RECV);
      e_busy  = (m_mode == M_RECV);
      e_done  = (m_mode == M_RUN);
      e_err   = (m_mode == M_ERR);
      e_core  = (m_mode != M_RUN);
    end
  end

  // ---------------- per-cycle compare + write log ----------------
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  always @(negedge CLK) begin
    if (check_en) begin
      chk("RxReady", 32'(RxReady), 32'(e_ready));
      chk("Busy",    32'(Busy),    32'(e_busy));
      chk("Done",    32'(Done),    32'(e_done));
      chk("Error",   32'(Error),   32'(e_err));
      chk("CoreRST", 32'(CoreRST), 32'(e_core));
      chk("ImemWE",  32'(ImemWE),  32'(e_we));
      if (e_we) begin
        chk("ImemAddr",  32'(ImemAddr), 32'(e_addr));
        chk("ImemWData", ImemWData,     e_wdata);
      end
    end
    if (ImemWE === 1'b1) begin
      wr_addr.push_back(ImemAddr);
      wr_data.push_back(ImemWData);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] frame[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    RxValid = 1'b1;
    RxData  = b;
    tick();
    RxValid = 1'b0;
    RxData  = 8'($urandom);
  endtask

  task automatic send_frame(input bit stall);
    foreach (frame[i]) begin
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          RxData = 8'($urandom);
          tick();
        end
      end
      send(frame[i]);
    end
  endtask

  task automatic reload();
    Reload = 1'b1;
    tick();
    Reload = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_good_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wr_data.size()), 32'd2);
    if (wr_data.size() == 2) begin
      chk({tag, "_a0"}, 32'(wr_addr[0]), 32'd0);
      chk({tag, "_d0"}, wr_data[0], 32'h12345678);
      chk({tag, "_a1"}, 32'(wr_addr[1]), 32'd1);
      chk({tag, "_d1"}, wr_data[1], 32'hDEADBEEF);
    end
  endtask

  initial begin
    // Reset held for two cycles
    tick();
    check_en = 1'b1;
    chk("rst_CoreRST", 32'(CoreRST), 32'd1);
    chk("rst_ImemWE",  32'(ImemWE),  32'd0);
    chk("rst_RxReady", 32'(RxReady), 32'd0);
    chk("rst_Busy",    32'(Busy),    32'd0);
    tick();
    RST = 1'b0;
    chk("rel_RxReady0", 32'(RxReady), 32'd0);
    tick();
    chk("rel_RxReady1", 32'(RxReady), 32'd1);
    chk("rel_Busy1",    32'(Busy),    32'd1);

    // Good image
    clear_log();
    frame = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    send_frame(1'b0);
    chk("good_Done",    32'(Done),    32'd1);
    chk("good_CoreRST", 32'(CoreRST), 32'd0);
    chk("good_Busy",    32'(Busy),    32'd0);
    check_good_writes("good");
    send(8'h55);
    chk("run_ignore", 32'(Done), 32'd1);

    // Bad checksum
    reload();
    chk("reload_CoreRST", 32'(CoreRST), 32'd1);
    chk("reload_Ready",   32'(RxReady), 32'd1);
    clear_log();
    frame[9] = 8'h2B;
    send_frame(1'b0);
    chk("bad_Error",   32'(Error),   32'd1);
    chk("bad_CoreRST", 32'(CoreRST), 32'd1);
    chk("bad_Ready",   32'(RxReady), 32'd0);
    check_good_writes("bad");

    // Overlength
    reload();
    clear_log();
    send(8'h41);
    chk("over_Error", 32'(Error), 32'd1);
    chk("over_Busy",  32'(Busy),  32'd0);
    tick();
    chk("over_nwr", 32'(wr_data.size()), 32'd0);

    // Empty frame
    reload();
    send(8'h00);
    chk("empty_Busy", 32'(Busy), 32'd1);
    send(8'h00);
    chk("empty_Done", 32'(Done), 32'd1);

    // Stalled good image
    reload();
    clear_log();
    frame[9] = 8'h2A;
    send_frame(1'b1);
    chk("stall_Done", 32'(Done), 32'd1);
    check_good_writes("stall");

    // Full-depth image: byte k = k, XOR of 0..255 is 0
    reload();
    clear_log();
    send(8'(DEPTH));
    for (int k = 0; k < 4 * DEPTH; k++) send(8'(k));
    chk("full_Busy", 32'(Busy), 32'd1);
    send(8'h00);
    chk("full_Done", 32'(Done), 32'd1);
    chk("full_nwr",  32'(wr_data.size()), 32'(DEPTH));
    if (wr_data.size() == DEPTH) begin
      chk("full_lastA", 32'(wr_addr[DEPTH-1]), 32'(DEPTH - 1));
      chk("full_lastD", wr_data[DEPTH-1], 32'hFFFEFDFC);
    end

    // Reload collides with the 3rd byte of word 0
    reload();
    clear_log();
    send(8'h01);
    send(8'h11);
    send(8'h22);
    Reload = 1'b1; RxValid = 1'b1; RxData = 8'h33;
    tick();
    Reload = 1'b0; RxValid = 1'b0;
    chk("abort_Busy",  32'(Busy),    32'd1);
    chk("abort_Ready", 32'(RxReady), 32'd1);
    tick();
    chk("abort_nwr", 32'(wr_data.size()), 32'd0);
    frame = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    send_frame(1'b0);
    chk("abort_Done", 32'(Done), 32'd1);
    chk("abort_nwr2", 32'(wr_data.size()), 32'd1);
    if (wr_data.size() == 1) chk("abort_d0", wr_data[0], 32'hDDCCBBAA);

    // RST pulsed mid-load
    reload();
    clear_log();
    send(8'h02);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    RST = 1'b1;
    #1;
    chk("arst_Ready",   32'(RxReady),   32'd0);
    chk("arst_WE",      32'(ImemWE),    32'd0);
    chk("arst_Addr",    32'(ImemAddr),  32'd0);
    chk("arst_WData",   ImemWData,      32'd0);
    chk("arst_CoreRST", 32'(CoreRST),   32'd1);
    chk("arst_Busy",    32'(Busy),      32'd0);
    chk("arst_Done",    32'(Done),      32'd0);
    chk("arst_Error",   32'(Error),     32'd0);
    tick();
    tick();
    RST = 1'b0;
    tick();
    chk("arst_nwr", 32'(wr_data.size()), 32'd0);
    frame = '{8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00};
    send_frame(1'b0);
    chk("post_Done", 32'(Done), 32'd1);
    if (wr_data.size() == 1) chk("post_d0", wr_data[0], 32'h0D0C0B0A);
    else chk("post_nwr", 32'(wr_data.size()), 32'd1);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader that sits directly upstream of `ProcessorStructural`. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into the processor's instruction memory. The loader holds the core in reset until the whole image has arrived and its checksum matches, then releases it. A `Reload` pulse re-arms the loader for a new image without a global reset.

## Interface
Parameters:
- `ADDR_W`, 6: instruction-memory word-address width; capacity `DEPTH = 2**ADDR_W` words.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `RxValid`  in  1  upstream byte valid.
- `RxData`  in  8  upstream byte.
- `RxReady`  out  1  loader can accept a byte; a byte is accepted on a rising edge with `RxValid && RxReady`.
- `Reload`  in  1  single-cycle request to abort or restart and wait for a new image.
- `ImemWE`  out  1  instruction-memory write strobe, one cycle per word.
- `ImemAddr`  out  ADDR_W  word address for the write.
- `ImemWData`  out  32  word data for the write.
- `CoreRST`  out  1  reset to `ProcessorStructural`; high until a valid image is loaded.
- `Busy`  out  1  high in LEN, LOAD and CHECK.
- `Done`  out  1  high in RUN.
- `Error`  out  1  high in ERR.

## Operation
- Frame format: one length byte `N` (words), then `4*N` data bytes, then one checksum byte. The checksum is the XOR of all data bytes; the length byte is excluded.
- States:
  - LEN: wait for the length byte. `N=0` → CHECK. `N>DEPTH` → ERR. Otherwise → LOAD, with word index 0 and running XOR 0.
  - LOAD: accept bytes into a byte lane counter (0..3). Lane 0 lands in `[7:0]` and lane 3 in `[31:24]`. Each accepted byte is XORed into the running checksum. On the 4th byte the assembled word is written, the word index increments and the lane counter wraps to 0. After the byte that completes word `N-1` → CHECK.
  - CHECK: accept one byte. If it equals the running XOR → RUN, otherwise → ERR.
  - RUN: `CoreRST=0`, `Done=1`, `RxReady=0`. Bytes are ignored.
  - ERR: `CoreRST=1`, `Error=1`, `RxReady=0`.
- `Reload` in any state → LEN on the next edge. It clears the word index, lane counter and XOR, and forces `CoreRST=1`. `Reload` has priority over a byte presented in the same cycle; that byte is not accepted.
- Memory contents beyond word `N-1` are not touched.

## Timing
- Reset values (while `RST=1`): `RxReady=0`, `ImemWE=0`, `ImemAddr=0`, `ImemWData=0`, `CoreRST=1`, `Busy=0`, `Done=0`, `Error=0`. The state is LEN.
- All outputs are registered.
  - `RxReady` and `Busy` go to 1 on the first rising edge after `RST` deasserts.
  - `RxReady` is 1 exactly while the state is LEN, LOAD or CHECK.
- Back-to-back bytes are accepted every cycle; there are no bubbles.
- Write latency: `ImemWE` is high for exactly the one cycle after the edge that accepted the 4th byte of a word. `ImemAddr` and `ImemWData` are valid in that same cycle. `ImemWE` is 0 at all other times.
- Run release: on the edge that accepts a matching checksum, `CoreRST` falls, `Done` rises and `Busy` falls, all in the same cycle. For `N=0`, the release follows a checksum byte of `0x00`.
- Failure: on the edge that accepts a mismatching checksum, or a length byte with `N>DEPTH`, `Error` rises and `Busy` falls. `CoreRST` stays 1.
- On `Reload`, `Done` and `Error` clear and `Busy` and `RxReady` rise on the next edge. `CoreRST` is 1 from that edge onward.
- When `RST` asserts mid-load, all outputs go to their reset values immediately (asynchronously). Partial words are discarded and no write is issued.
- `RxData` and `RxValid` are don't-care when `RxReady=0`.

## Test plan
- Reset: hold `RST=1` for 2 cycles, then release → `CoreRST=1`, `ImemWE=0`; `RxReady=1` and `Busy=1` one edge after release.
- Good image: send 02, 78 56 34 12, EF BE AD DE, 2A on consecutive cycles.
  - Expect `ImemWE` at addr 0 with `0x12345678`, then at addr 1 with `0xDEADBEEF`, each one cycle after the 4th byte of its word.
  - After byte 2A: `CoreRST=0`, `Done=1`.
- Bad checksum: send the same frame but with checksum 2B → `Error=1`, `CoreRST=1`, `RxReady=0`. The two writes still occur.
- Overlength and empty frames:
  - Length byte 0x41 with `ADDR_W=6` → ERR with no writes.
  - After `Reload`, length 00 then checksum 00 → RUN.
- Stalled stream: drop `RxValid` randomly during the good frame → identical writes and outcome.
- Abort paths:
  - `Reload` asserted in the same cycle as the 3rd byte of word 0 → that byte is not accepted, the state returns to LEN, and no write occurs.
  - `RST` pulsed mid-load → all outputs return to their reset values.
